// File: rtl/dcache_tag_update_sequencer_pkg.sv
// Shared types for the L1D tag-update sequencer.
// Set/tag/way index types, the tag write bundle and the sequencer states.
package dcache_tag_update_sequencer_pkg;

  localparam int L1D_NUM_WAYS  = 4;
  localparam int L1D_NUM_SETS  = 64;
  localparam int L1D_TAG_WIDTH = 20;
  localparam int L1D_SET_W     = $clog2(L1D_NUM_SETS);
  localparam int L1D_WAY_W     = $clog2(L1D_NUM_WAYS);

  typedef logic [L1D_SET_W-1:0]     l1d_set_idx_t;
  typedef logic [L1D_TAG_WIDTH-1:0] l1d_tag_t;
  typedef logic [L1D_WAY_W-1:0]     l1d_way_idx_t;

  typedef struct packed {
    l1d_set_idx_t            set;
    logic [L1D_NUM_WAYS-1:0] way_oh;
    l1d_tag_t                tag;
    logic                    valid;
  } tag_update_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FLUSH_WALK,
    SEQ_FLUSH_DONE
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, sync active-low reset; push allowed when full if popping.
// Ports: clk, reset, push/push_data, pop/pop_data, full, empty, almost_full.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= (AW+1)'(DEPTH-1));
  assign pop_data    = mem[rd_ptr];
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dcache_tag_update_sequencer.sv
// Owner of the L1D tag/valid write port: arbitrates fills, buffered
// invalidates and a flush-all walk. Optional perf events: DCACHE_TAG_SEQ_PERF_EN.
module dcache_tag_update_sequencer
  import dcache_tag_update_sequencer_pkg::*;
#(
  parameter int NUM_WAYS         = 4,
  parameter int NUM_SETS         = 64,
  parameter int TAG_WIDTH        = 20,
  parameter int INVAL_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fill_valid,
  output logic                        fill_ready,
  input  logic [$clog2(NUM_SETS)-1:0] fill_set,
  input  logic [NUM_WAYS-1:0]         fill_way_oh,
  input  logic [TAG_WIDTH-1:0]        fill_tag,
  input  logic                        inval_valid,
  output logic                        inval_ready,
  input  logic [$clog2(NUM_SETS)-1:0] inval_set,
  input  logic [NUM_WAYS-1:0]         inval_way_oh,
  input  logic                        flush_all_req,
  output logic                        flush_busy,
  output logic                        flush_done,
  output logic [NUM_WAYS-1:0]         dtag_update_en_oh,
  output logic [$clog2(NUM_SETS)-1:0] dtag_update_set,
  output logic [TAG_WIDTH-1:0]        dtag_update_tag,
  output logic                        dtag_update_valid
`ifdef DCACHE_TAG_SEQ_PERF_EN
  ,
  output logic                        perf_fill_stall,
  output logic                        perf_inval_full,
  output logic                        perf_walk_forced
`endif
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int PTR_W = SET_W + WAY_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam int FQ_W  = SET_W + NUM_WAYS;

  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(NUM_SETS*NUM_WAYS-1);
  localparam logic [CNT_W-1:0] STARVE_TOP =
    CNT_W'(STARVE_LIMIT-1);

  seq_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  starve_cnt;

  logic              fq_full;
  logic              fq_empty;
  logic              fq_almost_full;
  logic [FQ_W-1:0]   fq_head;
  logic              inval_push;

  logic              force_walk;
  logic              fill_go;
  logic              inval_go;
  logic              walk_go;

  sync_fifo #(
    .DEPTH (INVAL_FIFO_DEPTH),
    .WIDTH (FQ_W)
  ) u_inval_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (inval_push),
    .push_data   ({inval_set, inval_way_oh}),
    .pop         (inval_go),
    .pop_data    (fq_head),
    .full        (fq_full),
    .empty       (fq_empty),
    .almost_full (fq_almost_full)
  );

  // A walk starved for STARVE_LIMIT-1 cycles takes the next slot even
  // though invalidates are still queued.
  always_comb begin
    force_walk  = (state == SEQ_FLUSH_WALK)
                && (starve_cnt == STARVE_TOP) && !fq_empty;
    fill_ready  = (state == SEQ_IDLE) && !force_walk;
    fill_go     = fill_valid && fill_ready;
    inval_go    = !fq_empty && !force_walk && !fill_go;
    walk_go     = (state == SEQ_FLUSH_WALK) && !fill_go && !inval_go;
    // Full FIFO still accepts when its head drains this cycle.
    inval_ready = !fq_full || inval_go;
    inval_push  = inval_valid && inval_ready;
  end

`ifdef DCACHE_TAG_SEQ_PERF_EN
  assign perf_fill_stall  = fill_valid && !fill_ready;
  assign perf_inval_full  = inval_valid && !inval_ready;
  assign perf_walk_forced = force_walk;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= SEQ_IDLE;
      ptr               <= '0;
      starve_cnt        <= '0;
      flush_busy        <= 1'b0;
      flush_done        <= 1'b0;
      dtag_update_en_oh <= '0;
      dtag_update_set   <= '0;
      dtag_update_tag   <= '0;
      dtag_update_valid <= 1'b0;
    end else begin
      dtag_update_en_oh <= '0;
      flush_done        <= 1'b0;

      unique case (1'b1)
        fill_go: begin
          dtag_update_en_oh <= fill_way_oh;
          dtag_update_set   <= fill_set;
          dtag_update_tag   <= fill_tag;
          dtag_update_valid <= 1'b1;
        end
        inval_go: begin
          dtag_update_en_oh <= fq_head[NUM_WAYS-1:0];
          dtag_update_set   <= fq_head[FQ_W-1:NUM_WAYS];
          dtag_update_tag   <= '0;
          dtag_update_valid <= 1'b0;
        end
        walk_go: begin
          dtag_update_en_oh <= NUM_WAYS'(1) << ptr[WAY_W-1:0];
          dtag_update_set   <= ptr[PTR_W-1:WAY_W];
          dtag_update_tag   <= '0;
          dtag_update_valid <= 1'b0;
        end
        default: ;
      endcase

      case (state)
        SEQ_IDLE: begin
          if (flush_all_req) begin
            state      <= SEQ_FLUSH_WALK;
            ptr        <= '0;
            starve_cnt <= '0;
            flush_busy <= 1'b1;
          end
        end
        SEQ_FLUSH_WALK: begin
          if (walk_go) begin
            ptr        <= ptr + 1'b1;
            starve_cnt <= '0;
            if (ptr == PTR_LAST) begin
              state      <= SEQ_FLUSH_DONE;
              flush_busy <= 1'b0;
              flush_done <= 1'b1;
            end
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        SEQ_FLUSH_DONE: state <= SEQ_IDLE;
        default:        state <= SEQ_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      if (fill_valid)
        assert ($onehot(fill_way_oh))
          else $error("fill_way_oh not one-hot");
      if (inval_valid)
        assert ($onehot(inval_way_oh))
          else $error("inval_way_oh not one-hot");
      assert ($onehot0(dtag_update_en_oh))
        else $error("dtag_update_en_oh not onehot0");
      assert (!fq_full || fq_almost_full)
        else $error("inval fifo level flags disagree");
    end
  end

endmodule

// File: tb/tb_dcache_tag_update_sequencer.sv
// Directed bench for dcache_tag_update_sequencer.
// Covers reset, fills, invalidate ordering, back-pressure, flush and abort.
module tb_dcache_tag_update_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [5:0]  fill_set = '0;
  logic [3:0]  fill_way_oh = 4'b0001;
  logic [19:0] fill_tag = '0;
  logic        inval_valid = 1'b0;
  logic        inval_ready;
  logic [5:0]  inval_set = '0;
  logic [3:0]  inval_way_oh = 4'b0001;
  logic        flush_all_req = 1'b0;
  logic        flush_busy;
  logic        flush_done;
  logic [3:0]  en_oh;
  logic [5:0]  up_set;
  logic [19:0] up_tag;
  logic        up_valid;
`ifdef DCACHE_TAG_SEQ_PERF_EN
  logic        perf_fill_stall;
  logic        perf_inval_full;
  logic        perf_walk_forced;
`endif

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;

  dcache_tag_update_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .fill_valid        (fill_valid),
    .fill_ready        (fill_ready),
    .fill_set          (fill_set),
    .fill_way_oh       (fill_way_oh),
    .fill_tag          (fill_tag),
    .inval_valid       (inval_valid),
    .inval_ready       (inval_ready),
    .inval_set         (inval_set),
    .inval_way_oh      (inval_way_oh),
    .flush_all_req     (flush_all_req),
    .flush_busy        (flush_busy),
    .flush_done        (flush_done),
    .dtag_update_en_oh (en_oh),
    .dtag_update_set   (up_set),
    .dtag_update_tag   (up_tag),
    .dtag_update_valid (up_valid)
`ifdef DCACHE_TAG_SEQ_PERF_EN
    ,
    .perf_fill_stall   (perf_fill_stall),
    .perf_inval_full   (perf_inval_full),
    .perf_walk_forced  (perf_walk_forced)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (flush_done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc;
    int errs;
    int busy_n;
    int steps;
    logic walk;
    logic exp_walk;

    // Reset held with traffic present
    fill_valid   = 1'b1;
    fill_set     = 6'd1;
    fill_tag     = 20'h1;
    inval_valid  = 1'b1;
    inval_set    = 6'd2;
    inval_way_oh = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en_oh", 32'(en_oh), 32'h0);
    end
    reset       = 1'b1;
    fill_valid  = 1'b0;
    inval_valid = 1'b0;
    chk("rst_fill_ready", 32'(fill_ready), 32'h1);
    chk("rst_inval_ready", 32'(inval_ready), 32'h1);
    chk("rst_flush_busy", 32'(flush_busy), 32'h0);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    chk("rst_valid", 32'(up_valid), 32'h0);
    tick();
    chk("post_rst_idle", 32'(en_oh), 32'h0);

    // Single fill
    fill_valid  = 1'b1;
    fill_set    = 6'd5;
    fill_way_oh = 4'b0100;
    fill_tag    = 20'hABCDE;
    tick();
    fill_valid = 1'b0;
    chk("fill_en_oh", 32'(en_oh), 32'h4);
    chk("fill_set", 32'(up_set), 32'd5);
    chk("fill_tag", 32'(up_tag), 32'hABCDE);
    chk("fill_valid", 32'(up_valid), 32'h1);

    // Fill and invalidate to the same line together
    fill_valid   = 1'b1;
    fill_set     = 6'd3;
    fill_way_oh  = 4'b0001;
    fill_tag     = 20'h12345;
    inval_valid  = 1'b1;
    inval_set    = 6'd3;
    inval_way_oh = 4'b0001;
    tick();
    fill_valid  = 1'b0;
    inval_valid = 1'b0;
    chk("fvi_1_en", 32'(en_oh), 32'h1);
    chk("fvi_1_set", 32'(up_set), 32'd3);
    chk("fvi_1_valid", 32'(up_valid), 32'h1);
    chk("fvi_1_tag", 32'(up_tag), 32'h12345);
    tick();
    chk("fvi_2_en", 32'(en_oh), 32'h1);
    chk("fvi_2_set", 32'(up_set), 32'd3);
    chk("fvi_2_valid", 32'(up_valid), 32'h0);
    chk("fvi_2_tag", 32'(up_tag), 32'h0);
    tick();
    chk("fvi_3_idle", 32'(en_oh), 32'h0);

    // Invalidate back-pressure under continuous fills
    fill_valid   = 1'b1;
    fill_set     = 6'd7;
    fill_way_oh  = 4'b0010;
    fill_tag     = 20'h11111;
    inval_valid  = 1'b1;
    inval_way_oh = 4'b0001;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      inval_set = 6'(10 + i);
      chk("bp_ready", 32'(inval_ready), (i < 4) ? 32'h1 : 32'h0);
      if (inval_ready) acc++;
      tick();
      chk("bp_fill_en", 32'(en_oh), 32'h2);
    end
    fill_valid  = 1'b0;
    inval_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_drain_en", 32'(en_oh), 32'h1);
      chk("bp_drain_set", 32'(up_set), 32'(10 + i));
      chk("bp_drain_valid", 32'(up_valid), 32'h0);
    end
    tick();
    chk("bp_drained", 32'(en_oh), 32'h0);
    chk("bp_ready_back", 32'(inval_ready), 32'h1);

    // Full flush walk, no other traffic
    flush_all_req = 1'b1;
    tick();
    flush_all_req = 1'b0;
    chk("fl_start_en", 32'(en_oh), 32'h0);
    errs   = 0;
    busy_n = 0;
    for (int k = 0; k < 256; k++) begin
      if (flush_busy) busy_n++;
      if (fill_ready) errs++;
      tick();
      if (en_oh !== 4'(4'b0001 << (k % 4))) errs++;
      if (up_set !== 6'(k / 4)) errs++;
      if (up_valid !== 1'b0) errs++;
    end
    chk("fl_order_errs", 32'(errs), 32'd0);
    chk("fl_busy_cycles", 32'(busy_n), 32'd256);
    chk("fl_done_pulse", 32'(flush_done), 32'h1);
    chk("fl_busy_end", 32'(flush_busy), 32'h0);
    tick();
    chk("fl_done_clear", 32'(flush_done), 32'h0);
    chk("fl_done_count", 32'(done_cnt), 32'd1);
    chk("fl_fill_ready", 32'(fill_ready), 32'h1);
    chk("fl_idle_en", 32'(en_oh), 32'h0);

    // Walk under continuous invalidate pressure
    flush_all_req = 1'b1;
    inval_valid   = 1'b1;
    inval_set     = 6'd63;
    inval_way_oh  = 4'b1000;
    tick();
    flush_all_req = 1'b0;
    errs  = 0;
    steps = 0;
    for (int t = 1; t <= 800; t++) begin
      tick();
      walk     = (en_oh != 4'h0) && (up_set != 6'd63);
      exp_walk = (t % 8 == 0);
      if (walk !== exp_walk) errs++;
      if (walk) begin
        if (up_set !== 6'(steps / 4)) errs++;
        if (en_oh !== 4'(4'b0001 << (steps % 4))) errs++;
        steps++;
      end else if (en_oh !== 4'b1000) begin
        errs++;
      end
    end
    chk("st_pattern_errs", 32'(errs), 32'd0);
    chk("st_steps", 32'(steps), 32'd100);
    chk("st_busy", 32'(flush_busy), 32'h1);

    // Reset at pointer 100 aborts the walk
    reset       = 1'b0;
    inval_valid = 1'b0;
    tick();
    chk("ab_en", 32'(en_oh), 32'h0);
    chk("ab_busy", 32'(flush_busy), 32'h0);
    chk("ab_fill_ready", 32'(fill_ready), 32'h1);
    tick();
    reset = 1'b1;
    errs  = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (flush_busy !== 1'b0) errs++;
      if (en_oh !== 4'h0) errs++;
    end
    chk("ab_quiet_errs", 32'(errs), 32'd0);
    chk("ab_no_done", 32'(done_cnt), 32'd1);
    chk("ab_inval_ready", 32'(inval_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
